mem_port_arbiter: RTL

- Shares the processor's single-port program/data memory among three requesters: instruction fetch (0), datapath load/store (1), debug/program loader (2).
- Issues at most one memory access per cycle.
- Arbitration is round-robin with bounded bursts, plus a debug lock override.
- Routes read data back to the owning requester with a tagged valid pulse.
- Sits between the processor's datapath/control path, an external loader, and the memory.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: requester count,
//   requester IDs, the index type used for owner tracking and a helper
//   that steps an index round-robin.
package mem_arb_pkg;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  typedef logic [IDW-1:0] req_idx_t;

  typedef enum logic [IDW-1:0] {
    REQ_FETCH = 2'd0,
    REQ_DATA  = 2'd1,
    REQ_DBG   = 2'd2
  } req_id_e;

  // Next requester index in round-robin order, wrapping after the last one.
  function automatic req_idx_t next_idx(input req_idx_t i);
    if (i >= req_idx_t'(NREQ - 1)) begin
      return '0;
    end
    return i + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotating-priority picker. Starting at index 'start' and
//   walking upward with wrap, the first asserted request wins.
// Ports:
//   req    in  NREQ  request vector
//   start  in  IDW   index with highest priority this cycle
//   gnt    out NREQ  one-hot winner (zero when nothing requested)
//   found  out 1     some requester won
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_idx_t        start,
  output logic [NREQ-1:0] gnt,
  output logic            found
);

  req_idx_t idx;

  // Walk all requesters once from 'start'; 'found' stops later candidates
  // from also being granted.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = start;
    for (int n = 0; n < NREQ; n++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-port memory among instruction fetch (0),
//   datapath load/store (1) and the debug/program loader (2). One access per
//   cycle, round-robin with bounded bursts, and a debug lock that gives
//   requester 2 absolute priority. Read data returns one cycle after the
//   grant with a one-hot rvalid tag.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req, we         per-requester request / write enable (we qualified by req)
//   addr, wdata     packed per-requester address and write data
//   lock            debug lock for requester 2
//   gnt             one-hot combinational grant; that cycle is the access
//   rvalid, rdata   one-hot read-return tag and shared read data
//   mem_en, mem_we, mem_addr, mem_wdata   memory command
//   mem_rdata       memory read data, valid one cycle after a read command
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic                 lock,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST - 1);

  req_idx_t        last_owner;
  logic [3:0]      burst_cnt;
  logic            grant_prev;
  logic [NREQ-1:0] rd_tag;
  logic [AW-1:0]   addr_hold;
  logic [DW-1:0]   wdata_hold;

  logic [NREQ-1:0] rr_gnt;
  logic            rr_found;
  logic [NREQ-1:0] gnt_sel;
  req_idx_t        gnt_idx;
  logic            mem_we_c;
  logic [AW-1:0]   mem_addr_c;
  logic [DW-1:0]   mem_wdata_c;

  rr_pick u_rr_pick (
    .req   (req),
    .start (next_idx(last_owner)),
    .gnt   (rr_gnt),
    .found (rr_found)
  );

  // Grant selection: lock beats burst continuation, which beats round-robin.
  // Nothing is granted while reset is held so the memory stays idle.
  always_comb begin
    gnt_sel = '0;
    if (rst) begin
      gnt_sel = '0;
    end else if (lock && req[REQ_DBG]) begin
      gnt_sel[REQ_DBG] = 1'b1;
    end else if (grant_prev && req[last_owner] && (burst_cnt < BURST_LIMIT)) begin
      gnt_sel[last_owner] = 1'b1;
    end else if (rr_found) begin
      gnt_sel = rr_gnt;
    end
  end

  // Encode the granted requester and mux its command onto the memory port.
  // Without a grant, address and write data keep their last driven values.
  always_comb begin
    gnt_idx     = '0;
    mem_we_c    = 1'b0;
    mem_addr_c  = addr_hold;
    mem_wdata_c = wdata_hold;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_sel[i]) begin
        gnt_idx     = req_idx_t'(i);
        mem_we_c    = we[i];
        mem_addr_c  = addr[i*AW +: AW];
        mem_wdata_c = wdata[i*DW +: DW];
      end
    end
  end

  // Burst/owner bookkeeping, read-return tag and held memory command.
  // burst_cnt saturates so a long lock hold by requester 2 cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= REQ_DBG;
      burst_cnt  <= '0;
      grant_prev <= 1'b0;
      rd_tag     <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      rd_tag <= gnt_sel & ~we;
      if (|gnt_sel) begin
        if (grant_prev && (gnt_idx == last_owner)) begin
          burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
        end else begin
          burst_cnt <= '0;
        end
        last_owner <= gnt_idx;
        grant_prev <= 1'b1;
        addr_hold  <= mem_addr_c;
        wdata_hold <= mem_wdata_c;
      end else begin
        grant_prev <= 1'b0;
        burst_cnt  <= '0;
      end
    end
  end

  assign gnt       = gnt_sel;
  assign mem_en    = |gnt_sel;
  assign mem_we    = mem_we_c;
  assign mem_addr  = mem_addr_c;
  assign mem_wdata = mem_wdata_c;

  // A read in flight when reset arrives must never report its data.
  assign rvalid = rst ? '0 : rd_tag;
  assign rdata  = (|rvalid) ? mem_rdata : '0;

  a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_req    : assert property (@(posedge clk) (gnt & ~req) == '0);
  a_rv_onehot  : assert property (@(posedge clk) $onehot0(rvalid));

endmodule
